// File: rtl/sdram_init_seq_if.sv
// Command-side bundle of the SDRAM init sequencer: re-init request in,
// registered SDRAM command/address/bank and status flags out.
interface sdram_init_seq_if #(
    parameter int ASIZE = 13,
    parameter int BSIZE = 2
);
    logic             init_req;
    logic [3:0]       command;
    logic [ASIZE-1:0] address;
    logic [BSIZE-1:0] ba;
    logic             init_done;
    logic             busy;

    modport master (
        input  init_req,
        output command, address, ba, init_done, busy
    );

    modport slave (
        output init_req,
        input  command, address, ba, init_done, busy
    );
endinterface

// File: rtl/sdram_init_seq.sv
// SDRAM power-up / re-init sequencer: wait, PRECHARGE-ALL, REF_NUM auto
// refreshes, LOAD MODE REGISTER, then hold init_done until init_req.
module sdram_init_seq #(
    parameter int         ASIZE       = 13,
    parameter int         BSIZE       = 2,
    parameter int         T_POWERUP   = 20000,
    parameter int         T_RP        = 3,
    parameter int         T_RC        = 10,
    parameter int         T_MRD       = 2,
    parameter int         REF_NUM     = 2,
    parameter int         REINIT_WAIT = 4,
    parameter logic [2:0] MR_BL       = 3'b011,
    parameter logic       MR_BT       = 1'b0,
    parameter logic [2:0] MR_CL       = 3'b011,
    parameter logic       MR_WB       = 1'b0
) (
    input  logic             clk_100m,
    input  logic             rst,
    sdram_init_seq_if.master bus
);
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_POWERUP, T_RP), max2(T_RC, T_MRD)), REINIT_WAIT);
    localparam int CW    = $clog2(T_MAX) + 1;

    // A wait state entered one edge after its command leaves after D-1 edges,
    // i.e. when the in-state counter reads D-2.  D==1 skips the wait state.
    localparam int RP_END = (T_RP > 1)        ? T_RP - 2        : 0;
    localparam int RC_END = (T_RC > 1)        ? T_RC - 2        : 0;
    localparam int MR_END = (T_MRD > 1)       ? T_MRD - 2       : 0;
    localparam int RI_END = (REINIT_WAIT > 1) ? REINIT_WAIT - 2 : 0;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MSET = 4'b0000;

    localparam logic [ASIZE-1:0] ADDR_PALL = ASIZE'(11'h400);
    localparam logic [ASIZE-1:0] ADDR_MODE = ASIZE'({MR_WB, 2'b00, MR_CL, MR_BT, MR_BL});

    typedef enum logic [3:0] {
        WAIT_PU, PRE, WAIT_RP, AREF, WAIT_RC, MSET, WAIT_MRD, DONE, WAIT_RI
    } state_t;

    typedef struct packed {
        logic [3:0]       cmd;
        logic [ASIZE-1:0] addr;
        logic [BSIZE-1:0] ba;
    } sdram_cmd_t;

    state_t     state, next_state;
    logic [CW-1:0] cnt;
    logic [3:0] ref_cnt;
    logic       req_q;
    sdram_cmd_t out_q, nxt_out;
    logic       done_q, busy_q;

    always_comb begin
        next_state = state;
        case (state)
            WAIT_PU:  if (cnt == CW'(T_POWERUP)) next_state = PRE;
            PRE:      next_state = (T_RP > 1) ? WAIT_RP : AREF;
            WAIT_RP:  if (cnt == CW'(RP_END)) next_state = AREF;
            AREF: begin
                if (T_RC > 1)
                    next_state = WAIT_RC;
                else
                    next_state = ((ref_cnt + 4'd1) == 4'(REF_NUM)) ? MSET : AREF;
            end
            WAIT_RC:  if (cnt == CW'(RC_END))
                          next_state = (ref_cnt == 4'(REF_NUM)) ? MSET : AREF;
            MSET:     next_state = (T_MRD > 1) ? WAIT_MRD : DONE;
            WAIT_MRD: if (cnt == CW'(MR_END)) next_state = DONE;
            DONE:     if (req_q) next_state = (REINIT_WAIT > 1) ? WAIT_RI : PRE;
            WAIT_RI:  if (cnt == CW'(RI_END)) next_state = PRE;
            default:  next_state = WAIT_PU;
        endcase
    end

    // Outputs are decoded from the next state so commands leave on the
    // same edge the FSM enters the command state.
    always_comb begin
        nxt_out = '{cmd: CMD_NOP, addr: '0, ba: '0};
        case (next_state)
            PRE:     nxt_out = '{cmd: CMD_PRE,  addr: ADDR_PALL, ba: '0};
            AREF:    nxt_out = '{cmd: CMD_AREF, addr: '0,        ba: '0};
            MSET:    nxt_out = '{cmd: CMD_MSET, addr: ADDR_MODE, ba: '0};
            default: nxt_out = '{cmd: CMD_NOP,  addr: '0,        ba: '0};
        endcase
    end

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            state   <= WAIT_PU;
            cnt     <= '0;
            ref_cnt <= '0;
            req_q   <= 1'b0;
            out_q   <= '{cmd: CMD_NOP, addr: '0, ba: '0};
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state <= next_state;
            if (next_state != state)
                cnt <= '0;
            else if (state != DONE)
                cnt <= cnt + CW'(1);
            if (state == PRE)
                ref_cnt <= '0;
            else if (state == AREF)
                ref_cnt <= ref_cnt + 4'd1;
            // Requests are only captured while idle; nothing is queued.
            req_q  <= bus.init_req && (state == DONE);
            out_q  <= nxt_out;
            done_q <= (next_state == DONE);
            busy_q <= (next_state != DONE);
        end
    end

    assign bus.command   = out_q.cmd;
    assign bus.address   = out_q.addr;
    assign bus.ba        = out_q.ba;
    assign bus.init_done = done_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_sdram_init_seq.sv
// Scoreboard bench for sdram_init_seq: three configurations share clock and
// reset; expected commands are queued with stimulus and popped on output.
module tb_sdram_init_seq;
    localparam int         TPU    = 50;
    localparam int         BIG    = 1 << 30;
    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_AREF = 4'b0001;
    localparam logic [3:0] C_MSET = 4'b0000;

    typedef struct {
        int          cyc;
        logic [3:0]  cmd;
        logic [12:0] addr;
        logic [1:0]  ba;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = -100;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    exp_t exp_q[3][$];
    int   done_q[3][$];
    logic prev_done[3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= rst ? -1 : cyc + 1;

    sdram_init_seq_if #(.ASIZE(13), .BSIZE(2)) if0 ();
    sdram_init_seq_if #(.ASIZE(13), .BSIZE(2)) if1 ();
    sdram_init_seq_if #(.ASIZE(13), .BSIZE(2)) if2 ();

    sdram_init_seq #(.T_POWERUP(TPU)) u0 (.clk_100m(clk), .rst(rst), .bus(if0));
    sdram_init_seq #(.T_POWERUP(TPU), .REF_NUM(8), .T_RC(7)) u1 (.clk_100m(clk), .rst(rst), .bus(if1));
    sdram_init_seq #(.T_POWERUP(TPU), .MR_CL(3'b010), .MR_BL(3'b111), .MR_BT(1'b1), .MR_WB(1'b1))
        u2 (.clk_100m(clk), .rst(rst), .bus(if2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Expected events of one sequence starting with PRE at cycle pre;
    // only events before cycle limit are queued.
    task automatic push_seq(input int d, input int pre, input int nref, input int trc,
                            input logic [12:0] mr, input int limit);
        exp_t e;
        int   t;
        if (pre < limit) begin
            e = '{pre, C_PRE, 13'h0400, 2'b00};
            exp_q[d].push_back(e);
        end
        for (int n = 0; n < nref; n++) begin
            t = pre + 3 + n * trc;
            if (t < limit) begin
                e = '{t, C_AREF, 13'h0000, 2'b00};
                exp_q[d].push_back(e);
            end
        end
        t = pre + 3 + nref * trc;
        if (t < limit) begin
            e = '{t, C_MSET, mr, 2'b00};
            exp_q[d].push_back(e);
        end
        if (t + 2 < limit) done_q[d].push_back(t + 2);
    endtask

    task automatic mon(input int d, input logic [3:0] cmd, input logic [12:0] addr,
                       input logic [1:0] ba, input logic done, input logic busy);
        exp_t e;
        int   dc;
        chk($sformatf("d%0d_known@%0d", d, cyc), 32'($isunknown({cmd, addr, ba, done, busy})), 0);
        chk($sformatf("d%0d_busy@%0d", d, cyc), 32'(busy), 32'(!done));
        if (cmd !== C_NOP) begin
            if (exp_q[d].size() == 0) begin
                chk($sformatf("d%0d_unexpected_cmd@%0d", d, cyc), 32'(cmd), 32'(C_NOP));
            end else begin
                e = exp_q[d].pop_front();
                chk($sformatf("d%0d_cmd_cycle", d), cyc, e.cyc);
                chk($sformatf("d%0d_cmd@%0d", d, cyc), 32'(cmd), 32'(e.cmd));
                chk($sformatf("d%0d_addr_ba@%0d", d, cyc), 32'({addr, ba}), 32'({e.addr, e.ba}));
            end
        end else begin
            chk($sformatf("d%0d_nop_addr@%0d", d, cyc), 32'({addr, ba}), 0);
        end
        if (done === 1'b1 && prev_done[d] !== 1'b1) begin
            if (done_q[d].size() == 0) begin
                chk($sformatf("d%0d_unexpected_done@%0d", d, cyc), 32'(done), 0);
            end else begin
                dc = done_q[d].pop_front();
                chk($sformatf("d%0d_done_cycle", d), cyc, dc);
            end
        end
        prev_done[d] = done;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, if0.command, if0.address, if0.ba, if0.init_done, if0.busy);
            mon(1, if1.command, if1.address, if1.ba, if1.init_done, if1.busy);
            mon(2, if2.command, if2.address, if2.ba, if2.init_done, if2.busy);
        end
    end

    task automatic to_cyc(input int c);
        int n = 0;
        while (cyc != c) begin
            @(negedge clk);
            n++;
            if (n > 4000) begin
                checks++;
                failures++;
                $display("FAIL to_cyc timeout: at cycle %0d, required cycle %0d", cyc, c);
                return;
            end
        end
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_cmd0"}, 32'({if0.command, if0.address, if0.ba}), 32'({C_NOP, 15'h0}));
        chk({tag, "_cmd1"}, 32'({if1.command, if1.address, if1.ba}), 32'({C_NOP, 15'h0}));
        chk({tag, "_cmd2"}, 32'({if2.command, if2.address, if2.ba}), 32'({C_NOP, 15'h0}));
        chk({tag, "_flags0"}, 32'({if0.init_done, if0.busy}), 32'(2'b01));
        chk({tag, "_flags1"}, 32'({if1.init_done, if1.busy}), 32'(2'b01));
        chk({tag, "_flags2"}, 32'({if2.init_done, if2.busy}), 32'(2'b01));
    endtask

    task automatic push_all(input int limit);
        push_seq(0, TPU, 2, 10, 13'h0033, limit);
        push_seq(1, TPU, 8, 7,  13'h0033, limit);
        push_seq(2, TPU, 2, 10, 13'h022F, limit);
    endtask

    initial begin
        int t;
        if0.init_req = 1'b0;
        if1.init_req = 1'b0;
        if2.init_req = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) prev_done[d] = 1'b0;
        mon_en = 1'b1;
        rst_chk("reset");

        // Power-up with an init_req held through the sequence (must be ignored)
        push_all(BIG);
        rst = 1'b0;
        to_cyc(9);
        if0.init_req = 1'b1; if1.init_req = 1'b1; if2.init_req = 1'b1;
        to_cyc(60);
        if0.init_req = 1'b0; if1.init_req = 1'b0; if2.init_req = 1'b0;
        to_cyc(74);
        chk("d0_done_before", 32'(if0.init_done), 0);
        to_cyc(75);
        chk("d0_done_at75", 32'({if0.init_done, if0.busy}), 32'(2'b10));
        chk("d2_done_at75", 32'({if2.init_done, if2.busy}), 32'(2'b10));
        to_cyc(110);
        chk("d1_done_before", 32'(if1.init_done), 0);
        to_cyc(111);
        chk("d1_done_at111", 32'({if1.init_done, if1.busy}), 32'(2'b10));
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            chk($sformatf("d0_hold@%0d", cyc), 32'({if0.init_done, if0.busy}), 32'(2'b10));
        end

        // One-cycle re-init request on dut0, sampled at edge t
        t = 1120;
        to_cyc(t - 1);
        if0.init_req = 1'b1;
        push_seq(0, t + 4, 2, 10, 13'h0033, BIG);
        to_cyc(t);
        if0.init_req = 1'b0;
        chk("ri_done_at_T", 32'(if0.init_done), 1);
        to_cyc(t + 1);
        chk("ri_flags_T1", 32'({if0.init_done, if0.busy}), 32'(2'b01));
        to_cyc(t + 28);
        chk("ri_done_T28", 32'(if0.init_done), 0);
        to_cyc(t + 29);
        chk("ri_done_T29", 32'({if0.init_done, if0.busy}), 32'(2'b10));

        // Fresh reset, then a one-cycle reset sampled at edge 55
        to_cyc(t + 40);
        rst = 1'b1;
        @(negedge clk);
        rst_chk("reset2");
        push_all(55);
        rst = 1'b0;
        to_cyc(54);
        rst = 1'b1;
        @(negedge clk);
        rst_chk("midreset");
        chk("mid_q0_empty", exp_q[0].size(), 0);
        chk("mid_q1_empty", exp_q[1].size(), 0);
        push_all(BIG);
        rst = 1'b0;
        to_cyc(120);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d_cmd_q_drained", d), exp_q[d].size(), 0);
            chk($sformatf("d%0d_done_q_drained", d), done_q[d].size(), 0);
        end
        chk("final_flags0", 32'({if0.init_done, if0.busy}), 32'(2'b10));
        chk("final_flags1", 32'({if1.init_done, if1.busy}), 32'(2'b10));
        chk("final_flags2", 32'({if2.init_done, if2.busy}), 32'(2'b10));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
